// File: rtl/cos_controller.sv
// Moore FSM sequencing the cos(x) Taylor-series datapath with a start/done/ack host handshake.
// Optional feature: define COS_EARLY_EXIT_EN to also stop when not_continue=1 in CHECK.
module cos_controller #(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ack,
    input  logic              cnt_co,
    input  logic              not_continue,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              ld_y,
    output logic              init_cnt,
    output logic              init_pp,
    output logic              init_ps,
    output logic              init_TFF,
    output logic              ld_x2,
    output logic              ld_pp,
    output logic              ld_ps,
    output logic              inc_cnt,
    output logic              toggle,
    output logic              sel_x,
    output logic              sel_pp,
    output logic              sel_x2,
    output logic              sel_ROM
);

    typedef enum logic [2:0] {
        IDLE, INIT, SQR, MUL_X2, MUL_ROM, ACC, CHECK, DONE
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);

    state_t            state, next_state;
    logic [ITER_W-1:0] iter_q;
    logic              early_exit;
    logic              term;

`ifdef COS_EARLY_EXIT_EN
    assign early_exit = not_continue;
`else
    assign early_exit = 1'b0;
    // The port stays for datapath compatibility; the name marks it as deliberately unused.
    logic unused_not_continue;
    assign unused_not_continue = not_continue;
`endif

    // Loop ends on ROM exhaustion, the iteration cap, or (optionally) reached precision.
    assign term = cnt_co | (iter_q == MAX_ITER_V) | early_exit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            iter_q <= '0;
        end else begin
            state <= next_state;
            if (state == INIT) begin
                iter_q <= '0;
            end else if (state == ACC) begin
                iter_q <= iter_q + 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        ld_y       = 1'b0;
        init_cnt   = 1'b0;
        init_pp    = 1'b0;
        init_ps    = 1'b0;
        init_TFF   = 1'b0;
        ld_x2      = 1'b0;
        ld_pp      = 1'b0;
        ld_ps      = 1'b0;
        inc_cnt    = 1'b0;
        toggle     = 1'b0;
        sel_x      = 1'b0;
        sel_pp     = 1'b0;
        sel_x2     = 1'b0;
        sel_ROM    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = INIT;
            end
            INIT: begin
                ld_y       = 1'b1;
                init_cnt   = 1'b1;
                init_pp    = 1'b1;
                init_ps    = 1'b1;
                init_TFF   = 1'b1;
                next_state = SQR;
            end
            SQR: begin
                sel_x      = 1'b1;
                ld_x2      = 1'b1;
                next_state = MUL_X2;
            end
            MUL_X2: begin
                sel_pp     = 1'b1;
                sel_x2     = 1'b1;
                ld_pp      = 1'b1;
                next_state = MUL_ROM;
            end
            MUL_ROM: begin
                sel_pp     = 1'b1;
                sel_ROM    = 1'b1;
                ld_pp      = 1'b1;
                inc_cnt    = 1'b1;
                next_state = ACC;
            end
            ACC: begin
                ld_ps      = 1'b1;
                toggle     = 1'b1;
                next_state = CHECK;
            end
            CHECK: begin
                next_state = term ? DONE : MUL_X2;
            end
            DONE: begin
                done = 1'b1;
                if (ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_cos_controller.sv
// Scoreboard bench for cos_controller: directed runs push expectations, a negedge monitor checks them.
module tb_cos_controller;

    localparam int ITER_W = 4;
    localparam int MAX_IT = 3;

    logic clk = 1'b0;
    logic rst, start, ack, cnt_co, not_continue;
    logic busy, done;
    logic [ITER_W-1:0] iter_cnt;
    logic ld_y, init_cnt, init_pp, init_ps, init_TFF;
    logic ld_x2, ld_pp, ld_ps, inc_cnt, toggle;
    logic sel_x, sel_pp, sel_x2, sel_ROM;

    int checks   = 0;
    int failures = 0;
    int inits    = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int iter;
        int lat;
        int inc;
        int tog;
    } exp_t;

    exp_t exp_q[$];

    // Legal output patterns, one per state (busy,done,init strobes,loads,steps,selects).
    localparam logic [15:0] P_IDLE = 16'h0000;
    localparam logic [15:0] P_INIT = 16'hBE00;
    localparam logic [15:0] P_SQR  = 16'h8108;
    localparam logic [15:0] P_MX2  = 16'h8086;
    localparam logic [15:0] P_MROM = 16'h80A5;
    localparam logic [15:0] P_ACC  = 16'h8050;
    localparam logic [15:0] P_CHK  = 16'h8000;
    localparam logic [15:0] P_DONE = 16'hC000;

    logic [15:0] ov;
    assign ov = {busy, done, ld_y, init_cnt, init_pp, init_ps, init_TFF, ld_x2,
                 ld_pp, ld_ps, inc_cnt, toggle, sel_x, sel_pp, sel_x2, sel_ROM};

    cos_controller #(.MAX_ITER(MAX_IT), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .cnt_co(cnt_co),
        .not_continue(not_continue), .busy(busy), .done(done), .iter_cnt(iter_cnt),
        .ld_y(ld_y), .init_cnt(init_cnt), .init_pp(init_pp), .init_ps(init_ps),
        .init_TFF(init_TFF), .ld_x2(ld_x2), .ld_pp(ld_pp), .ld_ps(ld_ps),
        .inc_cnt(inc_cnt), .toggle(toggle), .sel_x(sel_x), .sel_pp(sel_pp),
        .sel_x2(sel_x2), .sel_ROM(sel_ROM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pattern legality every cycle, and per-computation latency/pulse counts at done.
    bit in_flight = 1'b0;
    int m_lat, m_inc, m_tog;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!(ov inside {P_IDLE, P_INIT, P_SQR, P_MX2, P_MROM, P_ACC, P_CHK, P_DONE})) begin
                failures++;
                $display("FAIL out_pattern: got 0x%04h expected a legal state pattern at %0t", ov, $time);
            end
            if (init_cnt) begin
                inits++;
                in_flight = 1'b1;
                m_lat = 0;
                m_inc = 0;
                m_tog = 0;
            end else if (in_flight) begin
                m_lat++;
                if (inc_cnt) m_inc++;
                if (toggle)  m_tog++;
                if (done) begin
                    in_flight = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_iter_cnt", 32'(iter_cnt), 32'(e.iter));
                        check("sb_latency",  32'(m_lat), 32'(e.lat));
                        check("sb_inc_cnt",  32'(m_inc), 32'(e.inc));
                        check("sb_toggle",   32'(m_tog), 32'(e.tog));
                    end
                end else if (!busy) begin
                    in_flight = 1'b0;  // aborted by reset
                end
            end
        end
    end

    // One computation. Inputs set at a negedge are sampled at the end of the state seen there.
    task automatic run(input int co_after, input int nc_after, input bit noise,
                       input bit hold_start, input int abort_at, input int exp_n,
                       input int ack_delay);
        int tcount = 0;
        bit got = 1'b0;
        bit is_chk;
        if (abort_at == 0) exp_q.push_back('{exp_n, 2 + 4 * exp_n, exp_n, exp_n});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("start_to_init", 32'(init_cnt), 32'd1);
        if (!hold_start) start = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (toggle) tcount++;
            if (done) got = 1'b1;
            is_chk = (ov == P_CHK);
            cnt_co       = is_chk ? (co_after > 0 && tcount >= co_after) : noise;
            not_continue = is_chk ? (nc_after > 0 && tcount >= nc_after) : noise;
            ack          = noise && !done;
            if (abort_at > 0 && inc_cnt && tcount == abort_at - 1) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                cnt_co = 1'b0;
                not_continue = 1'b0;
                ack = 1'b0;
                check("abort_outputs", 32'(ov), 32'(P_IDLE));
                check("abort_iter_cnt", 32'(iter_cnt), 32'd0);
                return;
            end
        end
        cnt_co = 1'b0;
        not_continue = 1'b0;
        ack = 1'b0;
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        check("done_iter_cnt", 32'(iter_cnt), 32'(exp_n));
        for (int d = 0; d < ack_delay; d++) begin
            @(negedge clk);
            check("done_held", 32'(done), 32'd1);
            check("done_iter_stable", 32'(iter_cnt), 32'(exp_n));
        end
        ack = 1'b1;
        @(negedge clk);
        check("ack_to_idle_busy", 32'(busy), 32'd0);
        check("ack_to_idle_done", 32'(done), 32'd0);
        check("idle_iter_hold", 32'(iter_cnt), 32'(exp_n));
        ack = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("no_queued_start", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ack = 1'b0;
        cnt_co = 1'b0;
        not_continue = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(ov), 32'(P_IDLE));
        check("reset_iter_cnt", 32'(iter_cnt), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("idle_without_start", 32'(busy), 32'd0);

        // Full run to the cap with noisy cnt_co/not_continue/ack outside CHECK/DONE.
        run(0, 0, 1'b1, 1'b0, 0, MAX_IT, 0);
        // ROM exhausted at the 2nd CHECK; host acks after 5 done cycles.
        run(2, 0, 1'b0, 1'b0, 0, 2, 4);
        // Precision reached at the 1st CHECK.
`ifdef COS_EARLY_EXIT_EN
        run(0, 1, 1'b0, 1'b0, 0, 1, 1);
`else
        run(0, 1, 1'b0, 1'b0, 0, MAX_IT, 1);
`endif
        // start held throughout, start+ack together in DONE.
        run(0, 0, 1'b0, 1'b1, 0, MAX_IT, 0);
        // Reset during MUL_ROM of iteration 2, then a clean run.
        run(0, 0, 1'b0, 1'b0, 2, 0, 0);
        run(0, 0, 1'b0, 1'b0, 0, MAX_IT, 2);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("init_count", 32'(inits), 32'd6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
